// File: rtl/satd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : satd_pkg                                               |
// | Description : Shared types, default widths and the saturating adder  |
// |               used by the SATD candidate accumulator.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package satd_pkg;

   localparam int C_SATD_W       = 16;
   localparam int C_ACC_W        = 24;
   localparam int C_ID_W         = 4;
   localparam int C_LAMBDA_SHIFT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Unsigned add clamped to 2^width-1; operands are zero-extended to 32 bits
   // by the caller and the result is truncated back to width by the caller.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/satd_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : satd_min_tracker                                       |
// | Description : Registered strict-less-than compare that keeps the     |
// |               lowest candidate cost and its id; ties keep the        |
// |               earlier id. clear restores the "no best yet" state.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module satd_min_tracker
   import satd_pkg::*;
#(
   parameter int ACC_W = C_ACC_W,
   parameter int ID_W  = C_ID_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [ACC_W-1:0] in_cost,
   input  logic [ID_W-1:0]  in_id,
   output logic [ACC_W-1:0] best_cost,
   output logic [ID_W-1:0]  best_id
);

   // Best-so-far register; clear wins over a coincident candidate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_cost <= '1;
         best_id   <= '0;
      end else if (clear) begin
         best_cost <= '1;
         best_id   <= '0;
      end else if (in_valid && (in_cost < best_cost)) begin
         best_cost <= in_cost;
         best_id   <= in_id;
      end
   end

endmodule
`default_nettype wire

// File: rtl/satd_cand_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : satd_cand_accum                                        |
// | Description : Sums 2^blk_log2 4x4 SATD beats per affine candidate    |
// |               with saturation, emits each candidate cost and tracks  |
// |               the minimum-cost candidate over a search.              |
// | Options     : SATD_RATE_COST_EN adds lambda/mvd_bits inputs and a    |
// |               rate term (lambda*mvd_bits)>>4 to every cost.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module satd_cand_accum
   import satd_pkg::*;
#(
   parameter int SATD_W = C_SATD_W,
   parameter int ACC_W  = C_ACC_W,
   parameter int ID_W   = C_ID_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        blk_log2,
   input  logic              sub_valid,
   input  logic [SATD_W-1:0] sub_satd,
   input  logic [ID_W-1:0]   sub_cand_id,
   input  logic              sub_cand_last,
`ifdef SATD_RATE_COST_EN
   input  logic [15:0]       lambda,
   input  logic [7:0]        mvd_bits,
`endif
   output logic              cand_valid,
   output logic [ACC_W-1:0]  cand_cost,
   output logic [ACC_W-1:0]  best_cost,
   output logic [ID_W-1:0]   best_id,
   output logic              busy,
   output logic              done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_blk_log2;
   logic [8:0]       r_beat_cnt;
   logic [8:0]       w_beat_max;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [ACC_W-1:0] w_cost;
   logic [ID_W-1:0]  r_cand_id;
   logic [ID_W-1:0]  w_cand_id;
   logic [ID_W-1:0]  r_cost_id;
   logic             r_cand_last;
   logic             w_cand_last;
   logic             w_beat;
   logic             w_first;
   logic             w_final;

   // Beat qualification; start takes the cycle so a coincident beat is dropped.
   always_comb begin
      w_beat_max  = 9'((10'd1 << r_blk_log2) - 10'd1);
      w_beat      = sub_valid && !start && (r_state == RUN);
      w_first     = (r_beat_cnt == 9'd0);
      w_final     = w_beat && (r_beat_cnt == w_beat_max);
      w_cand_id   = w_first ? sub_cand_id   : r_cand_id;
      w_cand_last = w_first ? sub_cand_last : r_cand_last;
      w_acc_nxt   = w_first ? ACC_W'(sub_satd)
                            : ACC_W'(sat_add(32'(r_acc), 32'(sub_satd), ACC_W));
   end

`ifdef SATD_RATE_COST_EN
   logic [15:0] r_lambda;
   logic [7:0]  r_mvd;
   logic [15:0] w_lambda;
   logic [7:0]  w_mvd;
   logic [23:0] w_rate_prod;

   // Rate term uses the beat-0 lambda/mvd, taken live when beat 0 is also final.
   always_comb begin
      w_lambda    = w_first ? lambda   : r_lambda;
      w_mvd       = w_first ? mvd_bits : r_mvd;
      w_rate_prod = 24'(w_lambda) * 24'(w_mvd);
      w_cost      = ACC_W'(sat_add(32'(w_acc_nxt),
                                   32'(w_rate_prod >> C_LAMBDA_SHIFT), ACC_W));
   end

   // Hold the rate inputs for the remaining beats of the candidate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lambda <= '0;
         r_mvd    <= '0;
      end else if (w_beat && w_first) begin
         r_lambda <= lambda;
         r_mvd    <= mvd_bits;
      end
   end
`else
   // Without the rate term the candidate cost is the SATD sum alone.
   always_comb begin
      w_cost = w_acc_nxt;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; start restarts the search from any state.
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = IDLE;
            RUN:     if (w_final && w_cand_last) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Beat counter, accumulator and per-candidate context capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_log2  <= '0;
         r_beat_cnt  <= '0;
         r_acc       <= '0;
         r_cand_id   <= '0;
         r_cand_last <= 1'b0;
      end else if (start) begin
         r_blk_log2  <= blk_log2;
         r_beat_cnt  <= '0;
         r_acc       <= '0;
      end else if (w_beat) begin
         r_acc       <= w_acc_nxt;
         r_beat_cnt  <= w_final ? 9'd0 : r_beat_cnt + 9'd1;
         if (w_first) begin
            r_cand_id   <= sub_cand_id;
            r_cand_last <= sub_cand_last;
         end
      end
   end

   // Completed-candidate output register, one cycle after the final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_valid <= 1'b0;
         cand_cost  <= '0;
         r_cost_id  <= '0;
      end else begin
         cand_valid <= w_final;
         if (w_final) begin
            cand_cost <= w_cost;
            r_cost_id <= w_cand_id;
         end
      end
   end

   // Status flags decoded from the registered state.
   always_comb begin
      busy = (r_state == RUN) || (r_state == FLUSH);
      done = (r_state == DONE);
   end

   satd_min_tracker #(
      .ACC_W (ACC_W),
      .ID_W  (ID_W)
   ) u_min_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start),
      .in_valid  (cand_valid),
      .in_cost   (cand_cost),
      .in_id     (r_cost_id),
      .best_cost (best_cost),
      .best_id   (best_id)
   );

endmodule
`default_nettype wire

// File: tb/tb_satd_cand_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_satd_cand_accum                                     |
// | Description : Directed self-checking bench for satd_cand_accum with  |
// |               a default-width instance and an ACC_W=16 instance      |
// |               sharing the same stimulus.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_satd_cand_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  blk_log2;
   logic        sub_valid;
   logic [15:0] sub_satd;
   logic [3:0]  sub_cand_id;
   logic        sub_cand_last;
`ifdef SATD_RATE_COST_EN
   logic [15:0] lambda;
   logic [7:0]  mvd_bits;
`endif

   logic        cand_valid;
   logic [23:0] cand_cost;
   logic [23:0] best_cost;
   logic [3:0]  best_id;
   logic        busy;
   logic        done;

   logic        cand_valid16;
   logic [15:0] cand_cost16;
   logic [15:0] best_cost16;
   logic [3:0]  best_id16;
   logic        busy16;
   logic        done16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   satd_cand_accum dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .blk_log2      (blk_log2),
      .sub_valid     (sub_valid),
      .sub_satd      (sub_satd),
      .sub_cand_id   (sub_cand_id),
      .sub_cand_last (sub_cand_last),
`ifdef SATD_RATE_COST_EN
      .lambda        (lambda),
      .mvd_bits      (mvd_bits),
`endif
      .cand_valid    (cand_valid),
      .cand_cost     (cand_cost),
      .best_cost     (best_cost),
      .best_id       (best_id),
      .busy          (busy),
      .done          (done)
   );

   satd_cand_accum #(.ACC_W(16)) dut16 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .blk_log2      (blk_log2),
      .sub_valid     (sub_valid),
      .sub_satd      (sub_satd),
      .sub_cand_id   (sub_cand_id),
      .sub_cand_last (sub_cand_last),
`ifdef SATD_RATE_COST_EN
      .lambda        (lambda),
      .mvd_bits      (mvd_bits),
`endif
      .cand_valid    (cand_valid16),
      .cand_cost     (cand_cost16),
      .best_cost     (best_cost16),
      .best_id       (best_id16),
      .busy          (busy16),
      .done          (done16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [15:0] satd, input logic [3:0] id, input logic last);
      sub_valid     = 1'b1;
      sub_satd      = satd;
      sub_cand_id   = id;
      sub_cand_last = last;
      tick();
      sub_valid     = 1'b0;
   endtask

   task automatic new_search(input logic [3:0] l2);
      start    = 1'b1;
      blk_log2 = l2;
      tick();
      start    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; blk_log2 = 4'd0; sub_valid = 1'b0;
      sub_satd = 16'd0; sub_cand_id = 4'd0; sub_cand_last = 1'b0;
`ifdef SATD_RATE_COST_EN
      lambda = 16'd0; mvd_bits = 8'd0;
`endif
      tick(); tick();
      chk("rst_best_cost",  32'(best_cost),  32'hFF_FFFF);
      chk("rst_best_id",    32'(best_id),    32'd0);
      chk("rst_cand_valid", 32'(cand_valid), 32'd0);
      chk("rst_cand_cost",  32'(cand_cost),  32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_done",       32'(done),       32'd0);
      rst_n = 1'b1;
      tick();

      // One 4-beat candidate with a gap between beats 2 and 3.
      new_search(4'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      beat(16'd10, 4'd0, 1'b1);
      beat(16'd20, 4'd0, 1'b1);
      tick();
      chk("t1_gap_no_valid", 32'(cand_valid), 32'd0);
      beat(16'd30, 4'd0, 1'b1);
      beat(16'd40, 4'd0, 1'b1);
      chk("t1_cand_valid", 32'(cand_valid), 32'd1);
      chk("t1_cand_cost",  32'(cand_cost),  32'd100);
      tick();
      chk("t1_best_cost", 32'(best_cost), 32'd100);
      chk("t1_best_id",   32'(best_id),   32'd0);
      chk("t1_done",      32'(done),      32'd1);
      chk("t1_busy_off",  32'(busy),      32'd0);
      tick();
      chk("t1_done_off", 32'(done), 32'd0);

      // Three 2-beat candidates, tie on the last one keeps id 7.
      new_search(4'd1);
      beat(16'd5, 4'd3, 1'b0);
      beat(16'd5, 4'd3, 1'b0);
      chk("t2_cost_id3", 32'(cand_cost), 32'd10);
      beat(16'd4, 4'd7, 1'b0);
      chk("t2_best_after_id3", 32'(best_cost), 32'd10);
      beat(16'd5, 4'd7, 1'b0);
      chk("t2_cost_id7", 32'(cand_cost), 32'd9);
      beat(16'd4, 4'd9, 1'b1);
      chk("t2_best_id_mid", 32'(best_id), 32'd7);
      beat(16'd5, 4'd9, 1'b1);
      chk("t2_cost_id9", 32'(cand_cost), 32'd9);
      chk("t2_busy_flush", 32'(busy), 32'd1);
      chk("t2_done_early", 32'(done), 32'd0);
      tick();
      chk("t2_best_cost", 32'(best_cost), 32'd9);
      chk("t2_best_id",   32'(best_id),   32'd7);
      chk("t2_done",      32'(done),      32'd1);
      tick();
      chk("t2_done_pulse", 32'(done), 32'd0);

      // Saturation: four 0xFFFF beats.
      new_search(4'd2);
      for (int i = 0; i < 4; i++) beat(16'hFFFF, 4'd1, 1'b1);
      chk("t3_cost16_sat", 32'(cand_cost16), 32'h0000_FFFF);
      chk("t3_cost24",     32'(cand_cost),   32'h0003_FFFC);
      tick(); tick();

      // Restart mid-candidate discards the partial sum and the old best.
      new_search(4'd2);
      beat(16'd8, 4'd2, 1'b0);
      beat(16'd8, 4'd2, 1'b0);
      new_search(4'd2);
      chk("t4_best_cleared", 32'(best_cost), 32'hFF_FFFF);
      for (int i = 0; i < 4; i++) beat(16'd1, 4'd5, 1'b1);
      chk("t4_cand_cost", 32'(cand_cost), 32'd4);
      tick();
      chk("t4_best_cost", 32'(best_cost), 32'd4);
      chk("t4_best_id",   32'(best_id),   32'd5);
      tick();

      // blk_log2=0, back-to-back single-beat candidates.
      new_search(4'd0);
      beat(16'd7, 4'd1, 1'b0);
      chk("t5_valid_a", 32'(cand_valid), 32'd1);
      chk("t5_cost_a",  32'(cand_cost),  32'd7);
      beat(16'd3, 4'd2, 1'b0);
      chk("t5_valid_b", 32'(cand_valid), 32'd1);
      chk("t5_cost_b",  32'(cand_cost),  32'd3);
      beat(16'd9, 4'd4, 1'b1);
      chk("t5_valid_c", 32'(cand_valid), 32'd1);
      chk("t5_cost_c",  32'(cand_cost),  32'd9);
      chk("t5_done_early", 32'(done), 32'd0);
      tick();
      chk("t5_best_cost", 32'(best_cost), 32'd3);
      chk("t5_best_id",   32'(best_id),   32'd2);
      chk("t5_done",      32'(done),      32'd1);
      tick();

      // Rate term: 100 + (32*6)>>4 = 112 when enabled, else 100.
      new_search(4'd0);
`ifdef SATD_RATE_COST_EN
      lambda = 16'd32; mvd_bits = 8'd6;
`endif
      beat(16'd100, 4'd6, 1'b1);
`ifdef SATD_RATE_COST_EN
      chk("t6_rate_cost", 32'(cand_cost), 32'd112);
`else
      chk("t6_rate_cost", 32'(cand_cost), 32'd100);
`endif
      tick(); tick();

      // Beats in IDLE are ignored.
      beat(16'd50, 4'd1, 1'b1);
      chk("t7_idle_valid", 32'(cand_valid), 32'd0);
      chk("t7_idle_busy",  32'(busy),       32'd0);
      tick();
      chk("t7_idle_valid2", 32'(cand_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
